// File: rtl/icache_pkg.sv
// Shared fetch/micro-op definitions used by the instruction cache.
// Holds line geometry, fetch width and the refill state encoding.
package icache_pkg;

   localparam int unsigned FETCH_WIDTH        = 4;    // 32-bit words per fetch
   localparam int unsigned ICACHE_LINE_BITS   = 128;
   localparam int unsigned ICACHE_OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage for the instruction cache.
// Ports:
//   clk, rst      : clock, async active-high reset (valid bits only)
//   rd_idx_i      : combinational read index -> rd_valid_o/rd_tag_o/rd_data_o
//   wr_en_i       : write tag/data at wr_idx_i, valid bit <= wr_valid_i
//   clr_all_i     : clear every valid bit; wins over a simultaneous write
module icache_array
   import icache_pkg::*;
#(
   parameter int unsigned SETS  = 64,
   parameter int unsigned IDX_W = $clog2(SETS),
   parameter int unsigned TAG_W = 32 - ICACHE_OFFSET_BITS - IDX_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IDX_W-1:0]            rd_idx_i,
   output logic                        rd_valid_o,
   output logic [TAG_W-1:0]            rd_tag_o,
   output logic [ICACHE_LINE_BITS-1:0] rd_data_o,
   input  logic                        wr_en_i,
   input  logic [IDX_W-1:0]            wr_idx_i,
   input  logic [TAG_W-1:0]            wr_tag_i,
   input  logic [ICACHE_LINE_BITS-1:0] wr_data_i,
   input  logic                        wr_valid_i,
   input  logic                        clr_all_i
);

   logic [SETS-1:0]             valid_q;
   logic [TAG_W-1:0]            tag_q  [SETS];
   logic [ICACHE_LINE_BITS-1:0] data_q [SETS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clr_all_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache with zero-latency hits.
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   core2icache_addr        : fetch address (offset bits ignored)
//   flush                   : invalidate all lines
//   icache2core_data(_valid): indexed line, valid only on an IDLE hit
//   icache2mem_req_*        : one refill request per miss, held until ready
//   mem2icache_resp_*       : refill line, single-cycle pulse
module icache
   import icache_pkg::*;
#(
   parameter int unsigned SETS = 64
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [31:0]                 core2icache_addr,
   input  logic                        flush,
   output logic [ICACHE_LINE_BITS-1:0] icache2core_data,
   output logic                        icache2core_data_valid,
   output logic                        icache2mem_req_valid,
   output logic [31:0]                 icache2mem_req_addr,
   input  logic                        mem2icache_req_ready,
   input  logic                        mem2icache_resp_valid,
   input  logic [ICACHE_LINE_BITS-1:0] mem2icache_resp_data
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 32 - ICACHE_OFFSET_BITS - IDX_W;

   icache_state_e state_q, state_d;
   logic [31:0]   miss_q, miss_d;
   logic          drop_q, drop_d;

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag_req;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic             wr_en, wr_valid;
   logic             unused_offset;

   assign rd_idx        = core2icache_addr[ICACHE_OFFSET_BITS +: IDX_W];
   assign rd_tag_req    = core2icache_addr[31 -: TAG_W];
   assign unused_offset = ^{core2icache_addr[ICACHE_OFFSET_BITS-1:0],
                            miss_q[ICACHE_OFFSET_BITS-1:0]};

   icache_array #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk        (clock),
      .rst        (reset),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (icache2core_data),
      .wr_en_i    (wr_en),
      .wr_idx_i   (miss_q[ICACHE_OFFSET_BITS +: IDX_W]),
      .wr_tag_i   (miss_q[31 -: TAG_W]),
      .wr_data_i  (mem2icache_resp_data),
      .wr_valid_i (wr_valid),
      .clr_all_i  (flush)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         miss_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      miss_d                 = miss_q;
      drop_d                 = drop_q;
      icache2core_data_valid = 1'b0;
      icache2mem_req_valid   = 1'b0;
      wr_en                  = 1'b0;
      wr_valid               = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!flush) begin
               if (rd_valid && (rd_tag == rd_tag_req)) begin
                  icache2core_data_valid = 1'b1;
               end else begin
                  miss_d  = {core2icache_addr[31:ICACHE_OFFSET_BITS],
                             {ICACHE_OFFSET_BITS{1'b0}}};
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            icache2mem_req_valid = 1'b1;
            if (flush) drop_d = 1'b1;
            if (mem2icache_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush) drop_d = 1'b1;
            if (mem2icache_resp_valid) begin
               // A flushed refill is still consumed but never marked valid.
               wr_en    = 1'b1;
               wr_valid = !drop_q && !flush;
               drop_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign icache2mem_req_addr = miss_q;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port core2icache_addr  input  32  fetch address from core (bits [3:0] ignored).
REQ-005 SHALL have port flush  input  1  invalidate all lines (fence.i).
REQ-006 SHALL have port icache2core_data  output  128  line for core2icache_addr; word i in bits [32i+31:32i].
REQ-007 SHALL have port icache2core_data_valid  output  1  icache2core_data is the correct line this cycle.
REQ-008 SHALL have port icache2mem_req_valid  output  1  refill request pending.
REQ-009 SHALL have port icache2mem_req_addr  output  32  16-byte-aligned refill address.
REQ-010 SHALL have port mem2icache_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port mem2icache_resp_valid  input  1  refill data valid, one-cycle pulse.
REQ-012 SHALL have port mem2icache_resp_data  input  128  refill line.

Function
REQ-013 Address split SHALL be offset [3:0], index [3+log2(SETS):4], tag = remaining upper bits.
REQ-014 Per line SHALL store valid bit, tag, 128-bit data.
REQ-015 States SHALL be IDLE, REQ, WAIT; reset state IDLE.
REQ-016 In IDLE, hit = valid[index] && tag match; icache2core_data_valid SHALL equal hit combinationally in same cycle (zero-latency hit) and SHALL be 0 in REQ/WAIT.
REQ-017 icache2core_data SHALL be the indexed line's data whenever icache2core_data_valid=1; value otherwise don't-care.
REQ-018 IDLE miss (flush=0) SHALL latch aligned address into miss register and go to REQ next cycle.
REQ-019 In REQ, icache2mem_req_valid=1 with icache2mem_req_addr = miss register, held stable until mem2icache_req_ready; on handshake go to WAIT.
REQ-020 icache2mem_req_valid SHALL be 0 outside REQ; exactly one request per miss.
REQ-021 In WAIT, on mem2icache_resp_valid SHALL write data and tag to line at miss index, set valid, return to IDLE; hit observable the following cycle.
REQ-022 Change of core2icache_addr during REQ/WAIT SHALL NOT cancel the refill; new address looked up after return to IDLE.
REQ-023 flush in IDLE SHALL clear all valid bits at next edge; icache2core_data_valid SHALL be 0 in the flush cycle.
REQ-024 flush in REQ/WAIT SHALL clear all valid bits and set a drop flag; the in-flight response SHALL be consumed without setting valid, then IDLE.
REQ-025 flush coincident with mem2icache_resp_valid SHALL leave the refilled line invalid.
REQ-026 mem2icache_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, clear all valid bits, drop flag and miss register, deassert icache2mem_req_valid and icache2core_data_valid, asynchronously.
REQ-028 Reset mid-refill SHALL abandon the refill; a late response SHALL be ignored.
REQ-029 Data and tag arrays SHALL NOT require reset.

Structure
REQ-030 ICACHE_LINE_BITS (128), ICACHE_OFFSET_BITS (4), and the refill state enum SHALL live in the shared micro-op package alongside FETCH_WIDTH.
REQ-031 Tag/valid/data storage SHALL be one sub-module icache_array (read port indexed combinationally, one write port, bulk valid clear).

Verification
REQ-032 After reset, addr 0x0000_0040 -> valid=0, req_valid=1 with req_addr 0x0000_0040 one cycle later.
REQ-033 Refill 0x0000_0040 with data 0x4444..._1111, ready=1, resp 3 cycles later -> next cycle addr 0x0000_004C gives valid=1 and that data.
REQ-034 Conflict: fill 0x0000_0000, then access 0x0000_0400 (SETS=64, same index) -> miss, refill; 0x0000_0000 then misses again.
REQ-035 Hold ready=0 for 5 cycles -> req_valid and req_addr stable all 5 cycles, single handshake.
REQ-036 flush during WAIT, then resp -> state IDLE, same address misses and re-requests.
REQ-037 Assert reset in WAIT, release, then pulse resp_valid -> no line valid, valid=0, new request issued for current address.
